// File: rtl/shift_counter_gen_if.sv
// Control and status bundle for shift_counter_gen.
// master: drives en/mode/dir/load/load_val, observes q/phase/q_legal/wrap/err.
// slave : the counter itself.
interface shift_counter_gen_if #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned PHASE_W = 3
);
    logic               en;
    logic               mode;
    logic               dir;
    logic               load;
    logic [WIDTH-1:0]   load_val;
    logic [WIDTH-1:0]   q;
    logic [PHASE_W-1:0] phase;
    logic               q_legal;
    logic               wrap;
    logic               err;

    modport master (
        output en, mode, dir, load, load_val,
        input  q, phase, q_legal, wrap, err
    );

    modport slave (
        input  en, mode, dir, load, load_val,
        output q, phase, q_legal, wrap, err
    );
endinterface

// File: rtl/shift_counter_gen.sv
// Parametrised ring / Johnson shift counter with run-time mode select,
// bidirectional shifting, parallel load and illegal-state self-correction.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   bus.en     advance one step
//   bus.mode   0 = ring, 1 = Johnson
//   bus.dir    0 = shift toward MSB, 1 = shift toward LSB
//   bus.load   parallel load strobe, bus.load_val is the value loaded
//   bus.q      registered counter state
//   bus.phase  combinational phase index decoded from q
//   bus.q_legal combinational legality of q for the registered mode
//   bus.wrap   registered pulse: last enabled step landed on phase 0
//   bus.err    registered pulse: an illegal state was corrected
module shift_counter_gen #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned PHASE_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    shift_counter_gen_if.slave  bus
);
    localparam int unsigned CYC_J = 2 * WIDTH;

    logic [WIDTH-1:0] q_r, q_n;
    logic             mode_q, mode_n;
    logic             wrap_r, wrap_n;
    logic             err_r, err_n;

    logic [WIDTH-1:0] q_inv;
    logic             johnson_legal;
    logic             ring_legal;
    logic             legal;
    logic [WIDTH-1:0] step_val;
    logic [PHASE_W-1:0] phase_j, phase_r;
    int unsigned      ones;

    // Home pattern: Johnson all zeros, ring only bit0 set.
    function automatic logic [WIDTH-1:0] home_of(input logic m);
        return m ? '0 : WIDTH'(1);
    endfunction

    // Legality: Johnson patterns are 0..01..1 or 1..10..0; ring is one-hot.
    always_comb begin
        q_inv         = ~q_r;
        johnson_legal = ((q_r & (q_r + WIDTH'(1))) == '0) ||
                        ((q_inv & (q_inv + WIDTH'(1))) == '0);
        ring_legal    = (q_r != '0) && ((q_r & (q_r - WIDTH'(1))) == '0);
        legal         = mode_q ? johnson_legal : ring_legal;
    end

    // Phase decode; popcount for Johnson, set-bit index for ring.
    always_comb begin
        ones    = 0;
        phase_r = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (q_r[i]) begin
                ones    = ones + 1;
                phase_r = PHASE_W'(i);
            end
        end
        // Runs anchored at bit0 count up; runs anchored at the MSB count down.
        if ((q_r == '0) || q_r[0]) begin
            phase_j = PHASE_W'(ones);
        end else begin
            phase_j = PHASE_W'(CYC_J - ones);
        end
    end

    // One legal step in the registered mode and current direction.
    always_comb begin
        step_val = q_r;
        case ({mode_q, bus.dir})
            2'b10:   step_val = {q_r[WIDTH-2:0], ~q_r[WIDTH-1]};
            2'b11:   step_val = {~q_r[0], q_r[WIDTH-1:1]};
            2'b00:   step_val = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
            default: step_val = {q_r[0], q_r[WIDTH-1:1]};
        endcase
    end

    // Next state: load > mode change > enabled step > hold.
    always_comb begin
        q_n    = q_r;
        mode_n = mode_q;
        wrap_n = 1'b0;
        err_n  = 1'b0;
        if (bus.load) begin
            q_n    = bus.load_val;
            mode_n = bus.mode;
        end else if (bus.mode != mode_q) begin
            q_n    = home_of(bus.mode);
            mode_n = bus.mode;
        end else if (bus.en) begin
            if (legal) begin
                q_n    = step_val;
                wrap_n = (step_val == home_of(mode_q));
            end else begin
                q_n   = home_of(mode_q);
                err_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_r    <= home_of(bus.mode);
            mode_q <= bus.mode;
            wrap_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            q_r    <= q_n;
            mode_q <= mode_n;
            wrap_r <= wrap_n;
            err_r  <= err_n;
        end
    end

    assign bus.q       = q_r;
    assign bus.wrap    = wrap_r;
    assign bus.err     = err_r;
    assign bus.q_legal = legal;
    assign bus.phase   = legal ? (mode_q ? phase_j : phase_r) : '0;
endmodule

// File: tb/tb_shift_counter_gen.sv
// Directed bench for shift_counter_gen: WIDTH=4 main instance plus a WIDTH=3
// instance for the shorter-period cycle checks.
module tb_shift_counter_gen;
    logic clk = 1'b0;
    logic reset;
    logic reset3;
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    shift_counter_gen_if #(.WIDTH(4), .PHASE_W(3)) bus ();
    shift_counter_gen_if #(.WIDTH(3), .PHASE_W(3)) bus3 ();

    shift_counter_gen #(.WIDTH(4), .PHASE_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    shift_counter_gen #(.WIDTH(3), .PHASE_W(3)) dut3 (
        .clk   (clk),
        .reset (reset3),
        .bus   (bus3.slave)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; bus.mode = 1'b1; bus.en = 1'b0; bus.dir = 1'b0;
        bus.load = 1'b0; bus.load_val = '0;
        tick();
        vecs++;
        if (bus.q !== 4'b0000 || bus.wrap !== 1'b0 || bus.err !== 1'b0 ||
            bus.phase !== 3'd0 || bus.q_legal !== 1'b1) begin
            $display("FAIL reset: q=%b wrap=%b err=%b phase=%0d legal=%b want q=0000 wrap=0 err=0 phase=0 legal=1",
                     bus.q, bus.wrap, bus.err, bus.phase, bus.q_legal);
            errs++;
        end
    endtask

    task automatic test_johnson_left;
        logic [3:0] eq [8];
        logic [2:0] ep [8];
        eq = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
        ep = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        reset = 1'b0; bus.en = 1'b1; bus.dir = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            vecs++;
            if (bus.q !== eq[i] || bus.phase !== ep[i] || bus.wrap !== (i == 7)) begin
                $display("FAIL johnson_left[%0d]: q=%b phase=%0d wrap=%b want q=%b phase=%0d wrap=%b",
                         i, bus.q, bus.phase, bus.wrap, eq[i], ep[i], (i == 7));
                errs++;
            end
        end
    endtask

    task automatic test_johnson_right;
        logic [3:0] eq [8];
        logic [2:0] ep [8];
        eq = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
        ep = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        bus.dir = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            vecs++;
            if (bus.q !== eq[i] || bus.phase !== ep[i] || bus.wrap !== (i == 7)) begin
                $display("FAIL johnson_right[%0d]: q=%b phase=%0d wrap=%b want q=%b phase=%0d wrap=%b",
                         i, bus.q, bus.phase, bus.wrap, eq[i], ep[i], (i == 7));
                errs++;
            end
        end
    endtask

    task automatic test_ring;
        logic [3:0] eq [9];
        logic [2:0] ep [9];
        logic [8:0] ew;
        logic [8:0] ed;
        // Left 0001->0010->0100->1000->0001->0010->0100, then right 0010,0001,1000.
        eq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
        ep = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd1, 3'd0, 3'd3};
        ew = 9'b0_1000_1000;
        ed = 9'b1_1100_0000;
        reset = 1'b1; bus.mode = 1'b0; bus.en = 1'b1; bus.dir = 1'b0;
        tick();
        reset = 1'b0;
        vecs++;
        if (bus.q !== 4'b0001 || bus.wrap !== 1'b0 || bus.q_legal !== 1'b1) begin
            $display("FAIL ring_reset: q=%b wrap=%b legal=%b want q=0001 wrap=0 legal=1",
                     bus.q, bus.wrap, bus.q_legal);
            errs++;
        end
        for (int i = 0; i < 9; i++) begin
            bus.dir = ed[i];
            tick();
            vecs++;
            if (bus.q !== eq[i] || bus.phase !== ep[i] || bus.wrap !== ew[i]) begin
                $display("FAIL ring[%0d]: q=%b phase=%0d wrap=%b want q=%b phase=%0d wrap=%b",
                         i, bus.q, bus.phase, bus.wrap, eq[i], ep[i], ew[i]);
                errs++;
            end
        end
    endtask

    task automatic test_illegal;
        bus.mode = 1'b1; bus.load = 1'b1; bus.load_val = 4'b0101; bus.en = 1'b1; bus.dir = 1'b0;
        tick();
        bus.load = 1'b0; bus.en = 1'b0;
        vecs++;
        if (bus.q !== 4'b0101 || bus.q_legal !== 1'b0 || bus.phase !== 3'd0 ||
            bus.err !== 1'b0 || bus.wrap !== 1'b0) begin
            $display("FAIL illegal_load: q=%b legal=%b phase=%0d err=%b wrap=%b want q=0101 legal=0 phase=0 err=0 wrap=0",
                     bus.q, bus.q_legal, bus.phase, bus.err, bus.wrap);
            errs++;
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            vecs++;
            if (bus.q !== 4'b0101 || bus.err !== 1'b0) begin
                $display("FAIL illegal_hold[%0d]: q=%b err=%b want q=0101 err=0", i, bus.q, bus.err);
                errs++;
            end
        end
        bus.en = 1'b1;
        tick();
        bus.en = 1'b0;
        vecs++;
        if (bus.q !== 4'b0000 || bus.err !== 1'b1 || bus.wrap !== 1'b0 || bus.q_legal !== 1'b1) begin
            $display("FAIL illegal_fix: q=%b err=%b wrap=%b legal=%b want q=0000 err=1 wrap=0 legal=1",
                     bus.q, bus.err, bus.wrap, bus.q_legal);
            errs++;
        end
        tick();
        vecs++;
        if (bus.err !== 1'b0 || bus.q !== 4'b0000) begin
            $display("FAIL illegal_pulse: q=%b err=%b want q=0000 err=0", bus.q, bus.err);
            errs++;
        end
    endtask

    task automatic test_mode_change;
        bus.en = 1'b1; bus.dir = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        vecs++;
        if (bus.q !== 4'b0111) begin
            $display("FAIL mode_setup: q=%b want 0111", bus.q);
            errs++;
        end
        bus.mode = 1'b0;
        tick();
        vecs++;
        if (bus.q !== 4'b0001 || bus.err !== 1'b0 || bus.wrap !== 1'b0 || bus.phase !== 3'd0) begin
            $display("FAIL mode_to_ring: q=%b err=%b wrap=%b phase=%0d want q=0001 err=0 wrap=0 phase=0",
                     bus.q, bus.err, bus.wrap, bus.phase);
            errs++;
        end
        bus.mode = 1'b1; bus.load = 1'b1; bus.load_val = 4'b1100;
        tick();
        bus.load = 1'b0; bus.en = 1'b0;
        vecs++;
        if (bus.q !== 4'b1100 || bus.phase !== 3'd6 || bus.q_legal !== 1'b1 || bus.wrap !== 1'b0) begin
            $display("FAIL load_wins: q=%b phase=%0d legal=%b wrap=%b want q=1100 phase=6 legal=1 wrap=0",
                     bus.q, bus.phase, bus.q_legal, bus.wrap);
            errs++;
        end
    endtask

    task automatic test_reset_mid;
        reset = 1'b1; bus.mode = 1'b1;
        tick();
        reset = 1'b0; bus.en = 1'b1; bus.dir = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        vecs++;
        if (bus.q !== 4'b1110) begin
            $display("FAIL reset_mid_setup: q=%b want 1110", bus.q);
            errs++;
        end
        reset = 1'b1; bus.load = 1'b1; bus.load_val = 4'b1011;
        tick();
        reset = 1'b0; bus.load = 1'b0; bus.en = 1'b0;
        vecs++;
        if (bus.q !== 4'b0000 || bus.wrap !== 1'b0 || bus.err !== 1'b0) begin
            $display("FAIL reset_mid: q=%b wrap=%b err=%b want q=0000 wrap=0 err=0",
                     bus.q, bus.wrap, bus.err);
            errs++;
        end
    endtask

    task automatic test_width3;
        logic [2:0] eq [6];
        logic [2:0] ep [6];
        logic [2:0] rq [3];
        eq = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000};
        ep = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        rq = '{3'b010, 3'b100, 3'b001};
        reset3 = 1'b1; bus3.mode = 1'b1; bus3.en = 1'b1; bus3.dir = 1'b0;
        bus3.load = 1'b0; bus3.load_val = '0;
        tick();
        reset3 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            vecs++;
            if (bus3.q !== eq[i] || bus3.phase !== ep[i] || bus3.wrap !== (i == 5)) begin
                $display("FAIL w3_johnson[%0d]: q=%b phase=%0d wrap=%b want q=%b phase=%0d wrap=%b",
                         i, bus3.q, bus3.phase, bus3.wrap, eq[i], ep[i], (i == 5));
                errs++;
            end
        end
        bus3.mode = 1'b0;
        tick();
        vecs++;
        if (bus3.q !== 3'b001 || bus3.wrap !== 1'b0) begin
            $display("FAIL w3_mode: q=%b wrap=%b want q=001 wrap=0", bus3.q, bus3.wrap);
            errs++;
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vecs++;
            if (bus3.q !== rq[i] || bus3.wrap !== (i == 2)) begin
                $display("FAIL w3_ring[%0d]: q=%b wrap=%b want q=%b wrap=%b",
                         i, bus3.q, bus3.wrap, rq[i], (i == 2));
                errs++;
            end
        end
        bus3.en = 1'b0;
    endtask

    initial begin
        reset3 = 1'b1;
        bus3.mode = 1'b1; bus3.en = 1'b0; bus3.dir = 1'b0;
        bus3.load = 1'b0; bus3.load_val = '0;
        #1;
        test_reset();
        test_johnson_left();
        test_johnson_right();
        test_ring();
        test_illegal();
        test_mode_change();
        test_reset_mid();
        test_width3();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/shift_counter_gen.md
Name: shift_counter_gen

Overview:
Parametrised ring/Johnson shift counter, the next generation of the team's fixed 4-bit Johnson counter. Selects ring or Johnson mode at run time, shifts in either direction, supports enable and parallel load, self-corrects illegal states, and reports phase index, wrap and error status. Used as a multi-phase clock-enable/sequencer source in timing and strobe-generation logic.

Parameters:
WIDTH, 4, counter width in bits; legal range 2..32.
PHASE_W, 3, phase index width; must equal clog2(2*WIDTH).

Ports:
clk  input  1  clock, all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
en  input  1  advance one step when high.
mode  input  1  0 = ring, 1 = Johnson (twisted ring).
dir  input  1  0 = shift left (toward MSB), 1 = shift right (toward LSB).
load  input  1  parallel load strobe.
load_val  input  WIDTH  value written to q on load.
q  output  WIDTH  registered counter state.
phase  output  PHASE_W  combinational phase index decoded from q.
q_legal  output  1  combinational: q is a legal pattern for the current mode.
wrap  output  1  registered 1-cycle pulse: last step landed on phase 0.
err  output  1  registered 1-cycle pulse: illegal state was corrected.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Home pattern: Johnson = all zeros; ring = only bit0 set.
- Reset: q = home pattern of mode sampled that cycle; mode_q = mode; wrap = 0; err = 0.
- Priority per edge: reset > load > mode change > enabled step > hold.
- load=1: q <= load_val unchanged (even if illegal); mode_q <= mode; wrap = err = 0.
- Mode change (mode != mode_q, no load): q <= home pattern of new mode; mode_q <= mode; no err, no wrap; en ignored that cycle.
- Enabled step, q legal:
  Johnson left: q <= {q[W-2:0], ~q[W-1]}; right: q <= {~q[0], q[W-1:1]}.
  Ring left: rotate left by 1; right: rotate right by 1.
- Enabled step, q illegal: q <= home pattern; err = 1 next cycle; wrap = 0.
- en=0: q holds; illegal q is not corrected until an enabled step.
- wrap = 1 for one cycle after a legal enabled step whose new q is phase 0; otherwise 0.
- dir may change any cycle; it takes effect on the next step with no correction.
- Legality:
  Johnson: q is all-0, all-1, or one contiguous run of ones touching bit0 or bit W-1 (2*WIDTH patterns).
  Ring: exactly one bit set.
- Phase decode, independent of dir:
  Johnson: if q==0 or q[0]==1, phase = popcount(q); else phase = 2*WIDTH - popcount(q). W=4 left sequence gives phases 0..7.
  Ring: phase = index of the set bit.
  Illegal q: phase = 0, q_legal = 0.
- Cycle lengths: Johnson 2*WIDTH, ring WIDTH. Wrap repeats at those periods in either direction.

Test Plan:
- Reset, mode=1, WIDTH=4, en=1, dir=0 for 9 clocks -> q = 0000,0001,0011,0111,1111,1110,1100,1000,0000; phase 0..7,0; wrap pulses once, on return to 0000.
- Mode=1, dir=1 from 0000 -> q = 1000,1100,1110,1111,0111,0011,0001,0000; phase = 7,6,5,4,3,2,1,0.
- Reset with mode=0, en=1, dir=0 -> q = 0001,0010,0100,1000,0001, wrap on 0001; dir=1 from 0100 -> 0010,0001,1000.
- Mode=1, load 0101 -> q_legal=0, phase=0; en=0 two cycles -> q holds 0101, err=0; en=1 -> q=0000, err pulses 1 cycle, wrap=0.
- Mode toggles 1->0 while en=1 at q=0111 -> next q=0001, no err, no wrap; load asserted with en and mode change in the same cycle -> load_val wins.
- Reset asserted mid-sequence at q=1110 with load=1 -> q=0000 next cycle; WIDTH=3 variant: Johnson period 6, ring period 3.
